rx: RTL

- Receive-side counterpart of the fibre link transmitter.
- Takes the raw serial line from the optical receiver, oversamples it and recovers framed bytes: start bit 0, 8 data bits LSB first, stop bit 1, idle line high.
- Each recovered byte is presented as a one-cycle write strobe into the rx FIFO.
- In PRBS mode it instead checks a PRBS-7 stream and counts bit errors for link BER measurement.

---
 rtl/rx_pkg.sv | 21 ++
 rtl/prbs7_check.sv | 94 +++++++++
 rtl/rx.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/rx_pkg.sv
// Shared types and constants for the fibre link receiver.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package rx_pkg;

    // Byte framing states
    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    // PRBS-7 (x^7 + x^6 + 1) taps into the received-bit history
    localparam int PRBS_TAP_A = 6;
    localparam int PRBS_TAP_B = 5;

    // Data bits per frame
    localparam int FRAME_BITS = 8;

endpackage

// File: rtl/prbs7_check.sv
// Self-synchronising PRBS-7 checker: mismatch detection, lock tracking, saturating error count.
// Latency: lock and error count update on the clock edge that consumes the bit.
// Backpressure: none; one bit is consumed every cycle bit_vld is high.
module prbs7_check
    import rx_pkg::*;
#(
    parameter int LOCK_BITS = 32,
    parameter int ERR_W     = 16
) (
    input  logic             clk_bit,
    input  logic             rst,
    input  logic             clr,
    input  logic             bit_vld,
    input  logic             bit_dat,
    output logic             lock,
    output logic [ERR_W-1:0] err_count
);

    localparam int WIN       = 64;
    localparam int ERR_LIMIT = 8;
    localparam int WIN_W     = $clog2(WIN + 1);
    localparam int RUN_W     = $clog2(LOCK_BITS + 1);

    logic [6:0]       hist;
    logic             mismatch;
    logic [RUN_W-1:0] run;
    logic [WIN-1:0]   win;
    logic [WIN_W-1:0] win_cnt;
    logic [WIN_W-1:0] win_next;

    // hist[0] is the newest bit, hist[6] the bit received seven bits ago
    assign mismatch = bit_dat ^ hist[PRBS_TAP_A] ^ hist[PRBS_TAP_B];

    // Sliding 64-bit error window count: add the new error, drop the one falling out
    assign win_next = win_cnt + WIN_W'(mismatch) - WIN_W'(win[WIN-1]);

    // Received-bit history
    always_ff @(posedge clk_bit or posedge rst) begin
        if (rst) begin
            hist <= '0;
        end else if (clr) begin
            hist <= '0;
        end else if (bit_vld) begin
            hist <= {hist[5:0], bit_dat};
        end
    end

    // Lock acquisition by match run length; loss by error density in the window.
    // The window only runs while locked so stale errors cannot kill a fresh lock.
    always_ff @(posedge clk_bit or posedge rst) begin
        if (rst) begin
            lock    <= 1'b0;
            run     <= '0;
            win     <= '0;
            win_cnt <= '0;
        end else if (clr) begin
            lock    <= 1'b0;
            run     <= '0;
            win     <= '0;
            win_cnt <= '0;
        end else if (bit_vld) begin
            if (!lock) begin
                win     <= '0;
                win_cnt <= '0;
                if (mismatch) begin
                    run <= '0;
                end else if (run == RUN_W'(LOCK_BITS - 1)) begin
                    run  <= '0;
                    lock <= 1'b1;
                end else begin
                    run <= run + RUN_W'(1);
                end
            end else begin
                win     <= {win[WIN-2:0], mismatch};
                win_cnt <= win_next;
                if (win_next >= WIN_W'(ERR_LIMIT)) begin
                    lock <= 1'b0;
                end
            end
        end
    end

    // Error count only accumulates while locked and sticks at all-ones
    always_ff @(posedge clk_bit or posedge rst) begin
        if (rst) begin
            err_count <= '0;
        end else if (clr) begin
            err_count <= '0;
        end else if (bit_vld && lock && mismatch && (err_count != '1)) begin
            err_count <= err_count + ERR_W'(1);
        end
    end

endmodule

// File: rtl/rx.sv
// Fibre link receiver: oversampled UART-style byte recovery, or PRBS-7 BER checking.
// Latency: d_out_valid / frame_err strobe one cycle after the stop-bit mid sample.
// Backpressure: none; each byte is a one-cycle write strobe the downstream FIFO must absorb.
module rx
    import rx_pkg::*;
#(
    parameter int OVERSAMPLE = 4,
    parameter int IDLE_BITS  = 16,
    parameter int LOCK_BITS  = 32,
    parameter int ERR_W      = 16
) (
    input  logic             clk_bit,
    input  logic             rst,
    input  logic             in,
    input  logic             prbs_on,
    output logic [7:0]       d_out,
    output logic             d_out_valid,
    output logic             frame_err,
    output logic             idle,
    output logic             prbs_lock,
    output logic [ERR_W-1:0] prbs_err_count
);

    localparam int PH_W = $clog2(OVERSAMPLE);
    localparam int IC_W = $clog2(IDLE_BITS + 1);

    localparam logic [PH_W-1:0] PH_MAX   = PH_W'(OVERSAMPLE - 1);
    localparam logic [PH_W-1:0] PH_MID   = PH_W'(OVERSAMPLE / 2 - 1);
    localparam logic [IC_W-1:0] IDLE_MAX = IC_W'(IDLE_BITS);

    logic            s_meta;
    logic            s;
    logic            s_prev;
    logic            prbs_on_d;
    logic            prbs_rise;
    logic [PH_W-1:0] phase;
    logic            mid;
    state_t          state;
    logic [7:0]      shift_reg;
    logic [2:0]      bit_idx;
    logic [IC_W-1:0] idle_cnt;

    assign mid       = (phase == PH_MID);
    assign prbs_rise = prbs_on & ~prbs_on_d;
    assign idle      = (idle_cnt == IDLE_MAX);

    // Two-flop synchroniser on the line, plus one more stage for edge detection
    always_ff @(posedge clk_bit or posedge rst) begin
        if (rst) begin
            s_meta <= 1'b1;
            s      <= 1'b1;
            s_prev <= 1'b1;
        end else begin
            s_meta <= in;
            s      <= s_meta;
            s_prev <= s;
        end
    end

    // Mode register for spotting the PRBS enable edge
    always_ff @(posedge clk_bit or posedge rst) begin
        if (rst) begin
            prbs_on_d <= 1'b0;
        end else begin
            prbs_on_d <= prbs_on;
        end
    end

    // Bit phase: realigned at a start edge (byte mode) or at every edge (PRBS mode).
    // In byte mode it then free-runs through the frame, so every later mid-bit
    // lands exactly OVERSAMPLE cycles after the previous one.
    always_ff @(posedge clk_bit or posedge rst) begin
        if (rst) begin
            phase <= '0;
        end else if ((prbs_on && (s != s_prev)) || (!prbs_on && (state == IDLE) && !s)) begin
            phase <= '0;
        end else if (phase == PH_MAX) begin
            phase <= '0;
        end else begin
            phase <= phase + PH_W'(1);
        end
    end

    // Byte framing FSM with registered strobes; PRBS mode holds it in IDLE
    always_ff @(posedge clk_bit or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            shift_reg   <= '0;
            bit_idx     <= '0;
            d_out       <= '0;
            d_out_valid <= 1'b0;
            frame_err   <= 1'b0;
        end else begin
            d_out_valid <= 1'b0;
            frame_err   <= 1'b0;
            if (prbs_on) begin
                state <= IDLE;
            end else begin
                case (state)
                    IDLE: begin
                        if (!s) begin
                            state <= START;
                        end
                    end
                    START: begin
                        if (mid) begin
                            if (s) begin
                                state <= IDLE;
                            end else begin
                                bit_idx <= '0;
                                state   <= DATA;
                            end
                        end
                    end
                    DATA: begin
                        if (mid) begin
                            shift_reg <= {s, shift_reg[7:1]};
                            bit_idx   <= bit_idx + 3'd1;
                            if (bit_idx == 3'(FRAME_BITS - 1)) begin
                                state <= STOP;
                            end
                        end
                    end
                    STOP: begin
                        if (mid) begin
                            if (s) begin
                                d_out       <= shift_reg;
                                d_out_valid <= 1'b1;
                            end else begin
                                frame_err <= 1'b1;
                            end
                            // Leave at mid-stop so a back-to-back start edge is caught early
                            state <= IDLE;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    // Idle detector: count high bit-times while waiting for a frame, saturating at IDLE_BITS
    always_ff @(posedge clk_bit or posedge rst) begin
        if (rst) begin
            idle_cnt <= '0;
        end else if ((state != IDLE) || !s) begin
            idle_cnt <= '0;
        end else if ((phase == PH_MAX) && (idle_cnt != IDLE_MAX)) begin
            idle_cnt <= idle_cnt + IC_W'(1);
        end
    end

    prbs7_check #(
        .LOCK_BITS (LOCK_BITS),
        .ERR_W     (ERR_W)
    ) u_prbs7_check (
        .clk_bit   (clk_bit),
        .rst       (rst),
        .clr       (prbs_rise),
        .bit_vld   (prbs_on & mid),
        .bit_dat   (s),
        .lock      (prbs_lock),
        .err_count (prbs_err_count)
    );

endmodule
